// File: rtl/iterative_arith_shifter_pkg.sv
// Shared types and constants for the iterative arithmetic right shifter.
package iterative_arith_shifter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Largest shift the combinational stage can apply in one pass.
    localparam int unsigned MAX_STEP = 3;

endpackage

// File: rtl/arithmetic_right_shifter.sv
// Combinational sign-extending right shifter, 0..3 positions per pass.
module arithmetic_right_shifter #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] data_in,
    input  logic [1:0]   control,
    output logic [N-1:0] data_out
);

    logic msb;
    assign msb = data_in[N-1];

    always_comb begin
        data_out = data_in;
        case (control)
            2'd0:    data_out = data_in;
            2'd1:    data_out = {msb, data_in[N-1:1]};
            2'd2:    data_out = {{2{msb}}, data_in[N-1:2]};
            2'd3:    data_out = {{3{msb}}, data_in[N-1:3]};
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/iterative_arith_shifter.sv
// Sequential arithmetic right shifter: applies up to MAX_STEP positions per clock
// until the requested amount is consumed, with valid/ready on both sides.
module iterative_arith_shifter
    import iterative_arith_shifter_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_data,
    output logic               busy
);

    localparam logic [SHAMT_W-1:0] MaxStepW = SHAMT_W'(MAX_STEP);

    state_e             state_q, state_d;
    logic [N-1:0]       data_q, data_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;

    logic [1:0]   step;
    logic         last_pass;
    logic [N-1:0] shifted;

    // Clamp the remaining amount to what one pass can do.
    always_comb begin
        last_pass = (rem_q <= MaxStepW);
        step      = last_pass ? rem_q[1:0] : 2'd3;
    end

    arithmetic_right_shifter #(
        .N (N)
    ) u_shifter (
        .data_in  (data_q),
        .control  (step),
        .data_out (shifted)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    data_d  = in_data;
                    rem_d   = in_shamt;
                    state_d = (in_shamt == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                data_d = shifted;
                rem_d  = rem_q - SHAMT_W'(step);
                if (last_pass) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

    // All outputs decode registered state only.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        out_data  = data_q;
    end

endmodule

// File: doc/iterative_arith_shifter.md
Name: iterative_arith_shifter

Overview:
Sequential wrapper around the team's combinational arithmetic_right_shifter, which shifts by at most 3 positions per pass. This block accepts an operand and an arbitrary shift amount over a valid/ready handshake. It applies repeated passes of up to 3 positions per clock until the full amount is done, then presents the sign-extended result over a valid/ready output handshake. It sits between the datapath operand source and the result consumer.

Parameters:
N, 8, operand/result width in bits (N >= 4)
SHAMT_W, 4, width of the shift-amount input; amounts 0..2^SHAMT_W-1 are legal, including amounts >= N

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  operand and amount valid
in_ready  out  1  block can accept an operand (high only in IDLE)
in_data  in  N  signed operand
in_shamt  in  SHAMT_W  total right-shift amount
out_valid  out  1  result valid (high only in DONE)
out_ready  in  1  consumer accepts result
out_data  out  N  shifted result
busy  out  1  high in SHIFT or DONE

Behaviour:
- Clocking and reset: one clock domain (clk). rst is asynchronous and active-high.
- Reset state:
  - state=IDLE; data_reg=0; rem_reg=0.
  - Outputs during/after reset: out_valid=0, out_data=0, busy=0, in_ready=1.
- States: IDLE, SHIFT, DONE. All outputs are decoded from registers; there is no combinational path from inputs to outputs.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: data_reg<=in_data, rem_reg<=in_shamt.
  - Next state is DONE if in_shamt==0, otherwise SHIFT.
- SHIFT, once per cycle:
  - step = min(rem_reg, 3).
  - data_reg <= arithmetic_right_shifter(data_reg, control=step[1:0]).
  - rem_reg <= rem_reg - step.
  - Go to DONE when rem_reg <= 3, otherwise stay in SHIFT.
- DONE:
  - out_valid=1 and out_data=data_reg, both held stable until out_ready.
  - On out_ready: go to IDLE, out_valid falls next cycle.
  - There is no same-cycle re-accept: in_ready=0 in DONE.
- Latency: the accept edge is cycle 0; out_valid is asserted from cycle 1+ceil(in_shamt/3).
  - Throughput is one operation per 2+ceil(in_shamt/3) cycles minimum.
- Arithmetic: result equals the signed in_data >>> in_shamt.
  - Amounts >= N saturate naturally: all bits equal the sign bit (0x00 or all-ones).
  - There is no special-case logic for large amounts.
- out_data: outside DONE it is don't-care for consumers, but it is driven from data_reg so it is never X after reset.
- Inputs ignored outside IDLE: in_valid, in_data and in_shamt have no effect in SHIFT or DONE.
- Reset mid-operation: rst asserted in SHIFT or DONE immediately returns to IDLE with reset values. The pending result is discarded; the consumer never sees out_valid for it.
- Backpressure: out_ready low holds DONE indefinitely with out_data unchanged.
- Simultaneous events: in_valid in the same cycle as out_ready in DONE is not accepted. It must be re-presented once in_ready=1.

Decomposition:
- Package iterative_arith_shifter_pkg:
  - state typedef (enum logic [1:0] {IDLE, SHIFT, DONE}).
  - localparam MAX_STEP=3.
- One sub-module: the existing arithmetic_right_shifter, instantiated with N and fed {data_reg, step[1:0]}. Its output is the next data_reg.
- Top level: FSM, rem_reg counter, step clamp, registers.

Test Plan (N=8, SHAMT_W=4):
1. in_data=0x96, in_shamt=5, out_ready=1 -> two SHIFT cycles (steps 3, 2), out_valid at cycle 3 after accept, out_data=0xFC.
2. in_data=0x5A, in_shamt=0 -> out_valid at cycle 1, out_data=0x5A; busy=1 only during DONE.
3. in_data=0x80, in_shamt=15 -> five SHIFT cycles, out_valid at cycle 6, out_data=0xFF. Repeat with in_data=0x7F -> out_data=0x00.
4. in_data=0x40, in_shamt=3, out_ready held 0 for 4 cycles, then 1:
   - out_data=0x08 stable and out_valid high throughout the stall.
   - in_ready=0 throughout; an in_valid pulse with 0x11 during the stall is ignored.
   - IDLE and in_ready=1 on the cycle after the handshake.
5. in_data=0x96, in_shamt=9, rst pulsed asynchronously (between clock edges) in the second SHIFT cycle:
   - Immediately: out_valid=0, out_data=0, busy=0, in_ready=1.
   - A new op 0x10, in_shamt=1 then yields 0x08.
6. Back-to-back ops with out_ready=1 (0xF0>>1, 0x0F>>4):
   - Results 0xF8, then 0x00.
   - Each op occupies IDLE for at least one cycle between operations; no result lost or duplicated.
